// File: rtl/sensor_pkg.sv
// Shared definitions for the doorway beam-break sensor conditioning path.
// Holds the default timing constants and the per-channel status struct that
// the occupancy block downstream also consumes.
package sensor_pkg;

  localparam int SENSOR_DB_CYCLES    = 8;
  localparam int SENSOR_STUCK_CYCLES = 1024;

  // Per-channel conditioned status.
  //   level : debounced sensor level
  //   rise  : one-cycle qualified 0->1 event of level
  //   stuck : level has been high for the stuck limit
  typedef struct packed {
    logic level;
    logic rise;
    logic stuck;
  } sensor_status_t;

endpackage : sensor_pkg

// File: rtl/sensor_conditioner_if.sv
// Bundle of the raw sensor inputs and conditioned event outputs at a doorway.
// Ports: raw_s1/raw_s2 (raw beam-break), s1/s2 (event pulses),
//        s1_level/s2_level (debounced levels), fault (stuck beam).
interface sensor_conditioner_if;

  logic raw_s1;
  logic raw_s2;
  logic s1;
  logic s2;
  logic s1_level;
  logic s2_level;
  logic fault;

  // Sensor side / stimulus: drives the raw beams, observes the events.
  modport master (
    output raw_s1, raw_s2,
    input  s1, s2, s1_level, s2_level, fault
  );

  // Conditioner side.
  modport slave (
    input  raw_s1, raw_s2,
    output s1, s2, s1_level, s2_level, fault
  );

endinterface : sensor_conditioner_if

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchroniser, debounce, rise detect, stuck count.
// Ports: clock, reset (async active-low), raw_i (async beam input),
//        status_o {level (registered), rise/stuck (next-edge indications)}.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DB_CYCLES    = SENSOR_DB_CYCLES,
  parameter int STUCK_CYCLES = SENSOR_STUCK_CYCLES,
  parameter int CNT_W        = $clog2(STUCK_CYCLES + 1)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           raw_i,
  output sensor_status_t status_o
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] ST_LIMIT = CNT_W'(STUCK_CYCLES);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] st_cnt_q, st_cnt_d;

  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    // Count cycles where the synchronised input disagrees with the level;
    // the level flips on the cycle the count would reach DB_CYCLES.
    if (sync_q[1] != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    st_cnt_d = st_cnt_q;
    if (!level_q) begin
      st_cnt_d = '0;
    end else if (st_cnt_q != ST_LIMIT) begin
      st_cnt_d = st_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      level_q  <= 1'b0;
      db_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      sync_q   <= {sync_q[0], raw_i};
      level_q  <= level_d;
      db_cnt_q <= db_cnt_d;
      st_cnt_q <= st_cnt_d;
    end
  end

  // rise and stuck describe the state being loaded at the coming edge, so the
  // parent can register its outputs in the same edge as level changes. Both
  // depend only on flops, never on raw_i directly.
  assign status_o.level = level_q;
  assign status_o.rise  = level_d & ~level_q;
  assign status_o.stuck = (st_cnt_d == ST_LIMIT);

endmodule : sensor_debounce

// File: rtl/sensor_conditioner.sv
// Doorway sensor conditioner: two debounced channels, coincident-event
// serialiser (s1 first, s2 deferred one cycle) and stuck-beam fault gating.
// Ports: clock, reset (async active-low), sif (slave: raw in, events out).
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int DB_CYCLES    = SENSOR_DB_CYCLES,
  parameter int STUCK_CYCLES = SENSOR_STUCK_CYCLES,
  parameter int CNT_W        = $clog2(STUCK_CYCLES + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  sensor_conditioner_if.slave   sif
);

  sensor_status_t st1, st2;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic pending_s2_q, pending_s2_d;
  logic fault_q, fault_d;

  sensor_debounce #(
    .DB_CYCLES   (DB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_ch1 (
    .clock   (clock),
    .reset   (reset),
    .raw_i   (sif.raw_s1),
    .status_o(st1)
  );

  sensor_debounce #(
    .DB_CYCLES   (DB_CYCLES),
    .STUCK_CYCLES(STUCK_CYCLES),
    .CNT_W       (CNT_W)
  ) u_ch2 (
    .clock   (clock),
    .reset   (reset),
    .raw_i   (sif.raw_s2),
    .status_o(st2)
  );

  always_comb begin
    fault_d = st1.stuck | st2.stuck;
    // Outer sensor wins a tie; the inner event is parked for one cycle. A
    // single pending bit suffices since one channel cannot rise twice in a row.
    s1_d         = st1.rise & ~fault_d;
    s2_d         = ~fault_d & (pending_s2_q | (st2.rise & ~st1.rise));
    pending_s2_d = ~fault_d & st1.rise & st2.rise;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      pending_s2_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      pending_s2_q <= pending_s2_d;
      fault_q      <= fault_d;
    end
  end

  assign sif.s1       = s1_q;
  assign sif.s2       = s2_q;
  assign sif.s1_level = st1.level;
  assign sif.s2_level = st2.level;
  assign sif.fault    = fault_q;

endmodule : sensor_conditioner

// File: doc/sensor_conditioner.md
# sensor_conditioner

Conditions the two raw beam-break sensors at a doorway into clean, single-cycle event pulses `s1`/`s2` for the occupancy FSM/counter directly downstream. Each input is synchronised, debounced and edge-detected. Coincident events are serialised so the downstream FSM never sees `s1` and `s2` in the same cycle. A beam held broken too long raises `fault` and suppresses events.

## Interface
- `DB_CYCLES`, 8: consecutive stable cycles required to change a debounced level; legal range ≥ 2.
- `STUCK_CYCLES`, 1024: consecutive cycles a debounced level may stay high before `fault` asserts; must be > `DB_CYCLES`.
- `CNT_W`, `$clog2(STUCK_CYCLES+1)`: width of the internal counters.

Ports:
- `clock` input, 1: system clock; all logic on the rising edge.
- `reset` input, 1: asynchronous, active-low.
- `raw_s1` input, 1: outer sensor, asynchronous; 1 = beam broken.
- `raw_s2` input, 1: inner sensor, asynchronous; 1 = beam broken.
- `s1` output, 1: one-cycle pulse on a qualified rising edge of `raw_s1`.
- `s2` output, 1: one-cycle pulse on a qualified rising edge of `raw_s2`.
- `s1_level` output, 1: debounced level of `raw_s1`.
- `s2_level` output, 1: debounced level of `raw_s2`.
- `fault` output, 1: a debounced level has been stuck high.

## Operation
- **Reset values.**
  - Synchroniser flops, levels, debounce counters, stuck counters, pending flag and all outputs are cleared.
  - All outputs are 0 while `reset` is low.
- **Synchroniser.** Each channel has a 2-flop synchroniser. The debounce logic sees only the second flop, `sync`.
- **Debounce, per channel.**
  - If `sync` equals `level`, the counter is cleared.
  - Otherwise the counter increments.
  - When the counter would reach `DB_CYCLES`, `level` takes `~level` and the counter clears.
  - A glitch shorter than `DB_CYCLES` cycles never changes `level`.
- **Edge qualification.** A 0→1 transition of `level` is a rise event. Falling transitions produce no pulse.
- **Serialiser.**
  - Rise events on both channels in the same cycle: `s1` pulses that cycle. `pending_s2` is set, and `s2` pulses the following cycle.
  - `s1` has priority; the outer sensor is treated as tripped first.
  - A single event pulses its own output immediately.
  - A one-deep pending flag is sufficient because `DB_CYCLES` ≥ 2 forbids back-to-back rises on one channel.
- **Stuck detection.**
  - A per-channel counter increments while `level` = 1 and clears when `level` = 0, saturating at `STUCK_CYCLES`.
  - `fault` is 1 whenever either counter has reached `STUCK_CYCLES`.
  - `fault` clears the cycle after both levels are 0.
- **Fault gating.**
  - While `fault` = 1, rise events are discarded, `s1`/`s2` are forced to 0, and `pending_s2` is cleared.
  - `s1_level`/`s2_level` keep tracking.
- **Arithmetic.** All counters are unsigned `CNT_W`, saturating, with no wrap.

## Timing
- **Rise latency.** Raw input first sampled high at edge n and held stable:
  - `sync` becomes 1 at edge n+1.
  - `level` rises and `s1`/`s2` pulse at edge n+1+`DB_CYCLES`.
  - Total latency is `DB_CYCLES`+2 edges including the sampling edge. With `DB_CYCLES` = 4, raw high from edge 0 gives the pulse at edge 5, high for 1 cycle.
- **Fall latency.** Identical, with no pulse.
- **Pulse width.** Exactly 1 cycle. The minimum spacing between pulses on one channel is 2·`DB_CYCLES` cycles.
- **Deferred pulse.** A deferred `s2` appears exactly 1 cycle after the coincident `s1`.
- **Fault timing.** `fault` asserts `STUCK_CYCLES` cycles after `level` rises.
- **Reset mid-operation.** Asynchronous assertion clears everything immediately, including an in-flight pending `s2`, which is lost. After deassertion, a raw input already high produces a pulse `DB_CYCLES`+2 edges later, so a beam broken through reset counts as a new event.
- **Outputs.** All outputs are registered; there are no combinational paths from inputs.

## Structure
- Package `sensor_pkg`:
  - default constants `SENSOR_DB_CYCLES` = 8 and `SENSOR_STUCK_CYCLES` = 1024;
  - a typedef for the per-channel status struct {`level`, `rise`, `stuck`}, shared with the downstream occupancy block.
- Sub-module `sensor_debounce`, instantiated twice: synchroniser, debounce counter, rise detect and stuck counter. It outputs `level`, a 1-cycle `rise` and `stuck`.
- Top level holds the serialiser, `pending_s2` and fault gating.

## Test plan
- Set `DB_CYCLES` = 4. Raise `raw_s1` at edge 0 and hold it → `s1` = 1 only at edge 5, `s1_level` = 1 from edge 5, `s2` stays 0.
- Pulse `raw_s1` high for 3 cycles, then low → `s1_level` and `s1` stay 0 throughout.
- Raise `raw_s1` and `raw_s2` at the same edge → `s1` at edge 5 and `s2` at edge 6, never both in one cycle.
- Full entry sequence: s1 high, then s2 high, s1 low, s2 low, each held 10 cycles → exactly one `s1` pulse then one `s2` pulse, in that order.
- Set `STUCK_CYCLES` = 20 and hold `raw_s2` high for 40 cycles → `fault` = 1 at 20 cycles after `s2_level` rises. A `raw_s1` rise during the fault gives no `s1` pulse. Release both → `fault` = 0 the cycle after both levels are low.
- Assert `reset` in the cycle between a coincident `s1` and its deferred `s2` → no `s2` pulse and all outputs 0. With `raw_s1` still high after release, `s1` pulses 6 edges later.
